// File: rtl/constant_encode_pkg.sv
// constant_encode_pkg
// Shared definitions for the constant encoder:
//   - encode_state_e : occupancy of the output register / skid buffer pair
//   - lfsr_taps()    : Galois (right-shift) tap mask for a maximal-length LFSR
//                      of the requested width
package constant_encode_pkg;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    FULL_SKID = 2'd2
  } encode_state_e;

  // Galois tap masks (bit k set = XOR into bit k when the shifted-out LSB is 1).
  // Widths 2..16 and 32 are maximal length; other widths fall back to the
  // 32-bit mask truncated by the caller and are not guaranteed maximal.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      2:       lfsr_taps = 32'h0000_0003;
      3:       lfsr_taps = 32'h0000_0006;
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0E08;
      13:      lfsr_taps = 32'h0000_1C80;
      14:      lfsr_taps = 32'h0000_3802;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_D008;
      default: lfsr_taps = 32'h8020_0003;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois
// Right-shifting Galois LFSR that advances only when step_i is high.
// A zero SEED would lock up the register, so it is replaced by 1.
// Ports:
//   clk_i   - clock, rising edge
//   arst_i  - asynchronous active-high reset, loads the seed
//   step_i  - advance one state on the next rising edge
//   value_o - current LFSR state
module lfsr_galois #(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] value_o
);

  localparam logic [WIDTH-1:0] SEED_EFF =
    (SEED == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

  logic [WIDTH-1:0] state_q, state_d;

  // Next state: shift right, fold the shifted-out bit back through the taps
  always_comb begin
    state_d = state_q;
    if (step_i) begin
      state_d = {1'b0, state_q[WIDTH-1:1]} ^ (state_q[0] ? TAPS : {WIDTH{1'b0}});
    end else begin
      state_d = state_q;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

  assign value_o = state_q;

endmodule

// File: rtl/constant_encode.sv
// constant_encode
// Turns a pattern index into a word that satisfies that pattern's compare
// mask / expected value: care bits come from EXP_RESULT, don't-care bits from
// an LFSR (or zero). Results pass through an output register plus a one-entry
// skid buffer so idx_ready_o is a pure register output.
// Build option: CONSTANT_ENCODE_LFSR_EN - when defined, don't-care bits are
// filled from an internal LFSR; when undefined they are 0 and no LFSR exists.
// Ports:
//   clk_i, arst_i            - clock, asynchronous active-high reset
//   idx_i/idx_valid_i/idx_ready_o   - request handshake
//   word_o/word_valid_o/word_ready_i - result handshake
//   idx_err_o  - sticky: an accepted index was >= NUM_PAT
//   issued_o   - wrapping count of consumed words
module constant_encode
  import constant_encode_pkg::*;
#(
  parameter int                              WIDTH       = 10,
  parameter int                              NUM_PAT     = 4,
  parameter logic [NUM_PAT-1:0][WIDTH-1:0]   CMP_ENABLES = {NUM_PAT{10'h0C3}},
  parameter logic [NUM_PAT-1:0][WIDTH-1:0]   EXP_RESULT  = {NUM_PAT{10'h082}},
  parameter logic [WIDTH-1:0]                LFSR_SEED   = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic [$clog2(NUM_PAT)-1:0] idx_i,
  input  logic                       idx_valid_i,
  output logic                       idx_ready_o,
  output logic [WIDTH-1:0]           word_o,
  output logic                       word_valid_o,
  input  logic                       word_ready_i,
  output logic                       idx_err_o,
  output logic [15:0]                issued_o
);

  encode_state_e    state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [15:0]      issued_q, issued_d;

  logic [WIDTH-1:0] lfsr_s;
  logic [WIDTH-1:0] mask_s;
  logic [WIDTH-1:0] val_s;
  logic [WIDTH-1:0] gen_s;
  logic             in_range_s;
  logic             accept_s;
  logic             consume_s;

  assign accept_s  = idx_valid_i & ready_q;
  assign consume_s = valid_q & word_ready_i;

`ifdef CONSTANT_ENCODE_LFSR_EN
  localparam logic [31:0] TAPS_ALL = lfsr_taps(WIDTH);

  // Steps once per accepted request so the sequence depends only on requests
  lfsr_galois #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS_ALL[WIDTH-1:0]),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .step_i  (accept_s),
    .value_o (lfsr_s)
  );
`else
  assign lfsr_s = {WIDTH{1'b0}};
`endif

  // Pattern lookup; an out-of-range index leaves mask/value at zero so the
  // word degenerates to the raw LFSR value
  always_comb begin
    mask_s     = {WIDTH{1'b0}};
    val_s      = {WIDTH{1'b0}};
    in_range_s = 1'b0;
    for (int p = 0; p < NUM_PAT; p++) begin
      if (int'(idx_i) == p) begin
        mask_s     = CMP_ENABLES[p];
        val_s      = EXP_RESULT[p];
        in_range_s = 1'b1;
      end else begin
        in_range_s = in_range_s;
      end
    end
    gen_s = (val_s & mask_s) | (lfsr_s & ~mask_s);
  end

  // Output/skid occupancy, data movement and status next-state
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept_s) begin
          out_d   = gen_s;
          state_d = FULL;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (accept_s && consume_s) begin
          out_d = gen_s;
        end else if (accept_s) begin
          skid_d  = gen_s;
          state_d = FULL_SKID;
        end else if (consume_s) begin
          out_d   = {WIDTH{1'b0}};
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      FULL_SKID: begin
        // idx_ready_o is low here, so only a consume can happen
        if (consume_s) begin
          out_d   = skid_q;
          skid_d  = {WIDTH{1'b0}};
          state_d = FULL;
        end else begin
          state_d = FULL_SKID;
        end
      end
      default: begin
        state_d = EMPTY;
        out_d   = {WIDTH{1'b0}};
        skid_d  = {WIDTH{1'b0}};
      end
    endcase

    // Handshake flags are registered copies of the next occupancy
    ready_d  = (state_d != FULL_SKID);
    valid_d  = (state_d != EMPTY);
    err_d    = err_q | (accept_s & ~in_range_s);
    issued_d = consume_s ? (issued_q + 16'd1) : issued_q;
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= EMPTY;
      out_q    <= {WIDTH{1'b0}};
      skid_q   <= {WIDTH{1'b0}};
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      issued_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      skid_q   <= skid_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      issued_q <= issued_d;
    end
  end

  assign idx_ready_o  = ready_q;
  assign word_o       = out_q;
  assign word_valid_o = valid_q;
  assign idx_err_o    = err_q;
  assign issued_o     = issued_q;

endmodule

// File: doc/constant_encode.md
# constant_encode

Sequential inverse of the constant-compare decoder: accepts a pattern index over a valid/ready handshake and emits a word that satisfies that pattern's compare mask and expected value. Care bits come from the parameter table and don't-care bits from an internal LFSR. Used by the core's built-in self-test path to generate legal and stress opcodes for the decode stage and its constant-compare matchers.

## Interface
- `WIDTH`, 10: output word width.
- `NUM_PAT`, 4: number of patterns in the table; must be ≥ 2.
- `CMP_ENABLES`, `{NUM_PAT{10'h0C3}}`: packed `[NUM_PAT-1:0][WIDTH-1:0]`; per-pattern care-bit mask.
- `EXP_RESULT`, `{NUM_PAT{10'h082}}`: packed `[NUM_PAT-1:0][WIDTH-1:0]`; per-pattern value on care bits.
- `LFSR_SEED`, `'h1`: `[WIDTH-1:0]`; a zero seed is replaced by 1.
- `clk_i` input 1: single clock, rising edge.
- `arst_i` input 1: reset, asynchronous and active-high.
- `idx_i` input `$clog2(NUM_PAT)`: requested pattern index.
- `idx_valid_i` input 1: request valid.
- `idx_ready_o` output 1: request accepted when `idx_valid_i && idx_ready_o`.
- `word_o` output `WIDTH`: generated word.
- `word_valid_o` output 1: `word_o` holds a result.
- `word_ready_i` input 1: consumer takes the word when `word_valid_o && word_ready_i`.
- `idx_err_o` output 1: sticky flag, set when an accepted `idx_i` is ≥ `NUM_PAT`.
- `issued_o` output 16: count of words consumed; wraps from `16'hFFFF` to 0.

## Operation
- One-entry output register plus a one-entry skid buffer. States are EMPTY, FULL and FULL_SKID (both entries occupied).
- `idx_ready_o` = state != FULL_SKID, driven from a register (no combinational path from `word_ready_i`).
- On accept, the generated word is `(EXP_RESULT[idx] & CMP_ENABLES[idx]) | (lfsr & ~CMP_ENABLES[idx])`.
- LFSR:
  - `WIDTH`-bit Galois LFSR with a maximal-length tap constant chosen per `WIDTH` from the package.
  - Advances exactly once per accepted request, never while idle, so output is deterministic per request sequence.
- Out-of-range index:
  - The word is produced with mask and value all-zero, so `word_o` is the raw LFSR value.
  - `idx_err_o` sets and stays set until reset.
- Transitions:
  - EMPTY + accept → FULL.
  - FULL + accept without consume → FULL_SKID.
  - FULL + consume without accept → EMPTY.
  - FULL + accept + consume → FULL, with the new word in the output register.
  - FULL_SKID + consume → FULL, with the skid word moved to the output register.
- `issued_o` increments on every consume handshake.
- Reset (asynchronous, at any point including mid-transfer): state EMPTY, both entries cleared, LFSR = seed, `issued_o` = 0, `idx_err_o` = 0. Any word in flight is discarded.

## Timing
- Reset values: `word_o`=0, `word_valid_o`=0, `idx_ready_o`=1, `idx_err_o`=0, `issued_o`=0.
- Latency: accept at edge N → `word_valid_o`=1 after edge N; the word is visible in cycle N+1.
- Sustained throughput: 1 word/cycle while `word_ready_i` is held high.
- `word_o` and `word_valid_o` are stable while `word_valid_o && !word_ready_i`.
- Accept and consume in the same cycle are both honoured; FIFO order is preserved.
- `idx_err_o` asserts the cycle after the offending accept.

## Configuration
- `CONSTANT_ENCODE_LFSR_EN` defined:
  - Don't-care bits are filled from the LFSR as described.
- `CONSTANT_ENCODE_LFSR_EN` undefined:
  - No LFSR is instantiated; don't-care bits are 0, so `word_o` = `EXP_RESULT[idx] & CMP_ENABLES[idx]`.
  - An out-of-range index yields `word_o`=0.
  - Handshake, latency, `idx_err_o` and `issued_o` are unchanged.

## Structure
- Shared package holds:
  - the LFSR tap lookup function, indexed by width;
  - the `encode_state_e` enum (EMPTY, FULL, FULL_SKID).
- One sub-module: `lfsr_galois`, with parameters width/taps/seed and ports `clk_i`, `arst_i`, `step_i`, `value_o`.
- The skid and output logic stays in `constant_encode`.

## Test plan
- Reset check: after reset deassertion with no requests → `word_valid_o`=0, `idx_ready_o`=1, `issued_o`=0.
- Care bits: LFSR disabled, request `idx`=0 with defaults → `word_o`=`10'h082`, valid the cycle after accept.
- Random stream: LFSR enabled, 1000 random in-range indices with random `word_ready_i` → every word satisfies `(word_o & CMP_ENABLES[idx]) == (EXP_RESULT[idx] & CMP_ENABLES[idx])`, no loss or duplication, order preserved.
- Backpressure: `word_ready_i`=0 with 3 requests offered → two accepted, then `idx_ready_o`=0. Release → words drain in order and `idx_ready_o` returns high the cycle after the first consume.
- Range and reset:
  - `NUM_PAT`=3, request `idx`=3 → `idx_err_o`=1 and sticky.
  - Reset asserted mid-stream → outputs return to reset values immediately and the LFSR restarts at the seed, so the first word after reset matches the first word after power-on.
- Counter wrap: 65536 consumes → `issued_o` wraps to 0.
